// File: rtl/rll_pkg.sv
// rll_pkg: shared constants, types and helpers for the RLL constrain encoder.
//   RLL_FLAG / RLL_TERM   marker flag digit and block-list terminator digit
//   RLL_IDX_DIGITS        base-4 digits per block index
//   RLL_BLK_DIGITS        digits per marker block (flag + index)
//   rll_digit_t           one 2-bit DNA digit
//   rll_state_e           encoder FSM states
//   idx_to_digits / digits_to_idx
//                         8-bit index <-> base-4 digits, element 0 least significant
package rll_pkg;

    typedef logic [1:0] rll_digit_t;

    localparam rll_digit_t RLL_FLAG       = 2'b11;
    localparam rll_digit_t RLL_TERM       = 2'b00;
    localparam rll_digit_t RLL_ZERO       = 2'b00;
    localparam int         RLL_IDX_DIGITS = 4;
    localparam int         RLL_BLK_DIGITS = 5;

    typedef rll_digit_t [RLL_IDX_DIGITS-1:0] rll_idx_digits_t;

    typedef enum logic [1:0] {
        RLL_IDLE,
        RLL_SCAN,
        RLL_PACK,
        RLL_DONE
    } rll_state_e;

    // Element i is placed at frame digit 5k+1+i, so element 0 is the
    // least significant base-4 digit of the index.
    function automatic rll_idx_digits_t idx_to_digits(input logic [7:0] idx);
        rll_idx_digits_t d;
        for (int i = 0; i < RLL_IDX_DIGITS; i++) begin
            d[i] = idx[2*i +: 2];
        end
        return d;
    endfunction

    function automatic logic [7:0] digits_to_idx(input rll_idx_digits_t d);
        logic [7:0] idx;
        for (int i = 0; i < RLL_IDX_DIGITS; i++) begin
            idx[2*i +: 2] = d[i];
        end
        return idx;
    endfunction

endpackage

// File: rtl/rll_hdr_pack.sv
// rll_hdr_pack: combinational frame assembly for the RLL constrain encoder.
//   comp      compressed payload, right-aligned, first-kept digit highest
//   clen      compressed payload length in digits
//   blk       block index list, entry k is the k-th block found
//   blk_cnt   number of valid entries in blk (R)
//   word_out  frame: R marker blocks, terminator, then the payload
//   out_len   frame length in digits (clen + 5R + 1)
module rll_hdr_pack
    import rll_pkg::*;
#(
    parameter int M       = 20,
    parameter int MAX_BLK = 4,
    localparam int LW     = $clog2(M + 3*MAX_BLK + 2),
    localparam int RW     = $clog2(MAX_BLK + 1),
    localparam int FW     = 2*(M + 1 + 3*MAX_BLK)
) (
    input  logic [2*M-1:0]             comp,
    input  logic [LW-1:0]              clen,
    input  logic [MAX_BLK-1:0][7:0]    blk,
    input  logic [RW-1:0]              blk_cnt,
    output logic [FW-1:0]              word_out,
    output logic [LW-1:0]              out_len
);

    logic [FW-1:0]   frame;
    rll_idx_digits_t dg;

    always_comb begin
        frame = '0;
        dg    = '0;
        for (int k = 0; k < MAX_BLK; k++) begin
            if (k < int'(blk_cnt)) begin
                dg = idx_to_digits(blk[k]);
                frame[2*RLL_BLK_DIGITS*k +: 2] = RLL_FLAG;
                for (int i = 0; i < RLL_IDX_DIGITS; i++) begin
                    frame[2*RLL_BLK_DIGITS*k + 2 + 2*i +: 2] = dg[i];
                end
            end
        end
        frame[2*RLL_BLK_DIGITS*int'(blk_cnt) +: 2] = RLL_TERM;
        // Payload starts one digit above the terminator. The compressed
        // payload register is zero above clen, so the frame stays zero
        // above out_len-1 without explicit masking.
        frame = frame | ({{(FW-2*M){1'b0}}, comp}
                         << (2*(RLL_BLK_DIGITS*int'(blk_cnt) + 1)));
    end

    assign word_out = frame;
    assign out_len  = LW'(int'(clen) + RLL_BLK_DIGITS*int'(blk_cnt) + 1);

endmodule

// File: rtl/rll_constrain.sv
// rll_constrain: run-length-limit encoder. Removes pairs of 00 digits from a
// payload word, one digit position per cycle, and records each removal as a
// marker block holding the pair position (from the payload top).
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; ready only while idle
//   word_in, in_len       right-aligned payload and its length in digits
//   out_valid / out_ready output handshake; frame held until accepted
//   word_out, out_len     encoded frame and its length in digits
//   blk_cnt               number of marker blocks in the frame
module rll_constrain
    import rll_pkg::*;
#(
    parameter int M       = 20,
    parameter int MAX_BLK = 4,
    localparam int LW     = $clog2(M + 3*MAX_BLK + 2),
    localparam int RW     = $clog2(MAX_BLK + 1),
    localparam int FW     = 2*(M + 1 + 3*MAX_BLK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*M-1:0]    word_in,
    input  logic [LW-1:0]     in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FW-1:0]     word_out,
    output logic [LW-1:0]     out_len,
    output logic [RW-1:0]     blk_cnt
);

    rll_state_e state_q, state_d;

    // Remaining payload, left-aligned: the digit at position p always sits
    // in the top two bits, so the scan never needs a variable digit index.
    logic [2*M-1:0]          work_q;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           p_q;
    logic [2*M-1:0]          comp_q;
    logic [LW-1:0]           clen_q;
    logic [MAX_BLK-1:0][7:0] blk_q;
    logic [RW-1:0]           r_q;

    logic [FW-1:0]           word_q;
    logic [LW-1:0]           olen_q;
    logic [RW-1:0]           cnt_q;

    logic [LW-1:0]           len_sat;
    rll_digit_t              top_dig;
    rll_digit_t              nxt_dig;
    logic                    scan_end;
    logic                    take_pair;
    logic [FW-1:0]           pack_word;
    logic [LW-1:0]           pack_len;

    assign len_sat   = (in_len > LW'(M)) ? LW'(M) : in_len;
    assign top_dig   = work_q[2*M-1 -: 2];
    assign nxt_dig   = work_q[2*M-3 -: 2];
    assign scan_end  = (p_q >= len_q);
    assign take_pair = (top_dig == RLL_ZERO) && (nxt_dig == RLL_ZERO)
                       && ((p_q + LW'(1)) < len_q)
                       && (r_q < RW'(MAX_BLK));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RLL_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RLL_IDLE: if (in_valid)  state_d = RLL_SCAN;
            RLL_SCAN: if (scan_end)  state_d = RLL_PACK;
            RLL_PACK:                state_d = RLL_DONE;
            RLL_DONE: if (out_ready) state_d = RLL_IDLE;
            default:                 state_d = RLL_IDLE;
        endcase
    end

    assign in_ready  = (state_q == RLL_IDLE);
    assign out_valid = (state_q == RLL_DONE);

    // ------------------------------------------------------------------
    // Scan datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            len_q  <= '0;
            p_q    <= '0;
            comp_q <= '0;
            clen_q <= '0;
            blk_q  <= '0;
            r_q    <= '0;
        end else if (state_q == RLL_IDLE) begin
            if (in_valid) begin
                // Shifting left drops any bits above the payload top.
                work_q <= word_in << (2*(M - int'(len_sat)));
                len_q  <= len_sat;
                p_q    <= '0;
                comp_q <= '0;
                clen_q <= '0;
                blk_q  <= '0;
                r_q    <= '0;
            end
        end else if (state_q == RLL_SCAN && !scan_end) begin
            if (take_pair) begin
                for (int k = 0; k < MAX_BLK; k++) begin
                    if (RW'(k) == r_q) blk_q[k] <= 8'(p_q);
                end
                r_q    <= r_q + RW'(1);
                p_q    <= p_q + LW'(2);
                work_q <= work_q << 4;
            end else begin
                // Kept digits enter at the bottom, so the first one kept
                // ends up highest: original order, top digit highest.
                comp_q <= {comp_q[2*M-3:0], top_dig};
                clen_q <= clen_q + LW'(1);
                p_q    <= p_q + LW'(1);
                work_q <= work_q << 2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly and output registers
    // ------------------------------------------------------------------
    rll_hdr_pack #(
        .M       (M),
        .MAX_BLK (MAX_BLK)
    ) u_pack (
        .comp     (comp_q),
        .clen     (clen_q),
        .blk      (blk_q),
        .blk_cnt  (r_q),
        .word_out (pack_word),
        .out_len  (pack_len)
    );

    // Output registers load only in PACK, so the frame is stable throughout
    // DONE regardless of out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            olen_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == RLL_PACK) begin
            word_q <= pack_word;
            olen_q <= pack_len;
            cnt_q  <= r_q;
        end
    end

    assign word_out = word_q;
    assign out_len  = olen_q;
    assign blk_cnt  = cnt_q;

endmodule

// File: tb/tb_rll_constrain.sv
module tb_rll_constrain;

    localparam int M       = 20;
    localparam int MAX_BLK = 4;
    localparam int LW      = $clog2(M + 3*MAX_BLK + 2);
    localparam int RW      = $clog2(MAX_BLK + 1);
    localparam int FD      = M + 1 + 3*MAX_BLK;
    localparam int FW      = 2*FD;

    typedef struct {
        logic [FW-1:0] w;
        int            len;
        int            cnt;
        int            lat;
        int            acc;
    } exp_t;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [2*M-1:0]    word_in = '0;
    logic [LW-1:0]     in_len = '0;
    logic              out_valid;
    logic              out_ready = 0;
    logic [FW-1:0]     word_out;
    logic [LW-1:0]     out_len;
    logic [RW-1:0]     blk_cnt;

    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    logic ov_q = 0;
    exp_t sb[$];

    rll_constrain #(.M(M), .MAX_BLK(MAX_BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word_in   (word_in),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_out  (word_out),
        .out_len   (out_len),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: apply the removal rules over a digit list, then lay
    // the frame out digit by digit.
    function automatic exp_t model(input logic [2*M-1:0] w, input int len);
        exp_t e;
        int   L;
        int   p;
        int   a;
        int   b;
        int   pos;
        int   idx[$];
        int   pay[$];
        int   fd[FD];
        L = (len > M) ? M : len;
        p = 0;
        while (p < L) begin
            a = int'((w >> (2*(L-1-p))) & 3);
            b = (p + 1 < L) ? int'((w >> (2*(L-2-p))) & 3) : -1;
            if (a == 0 && b == 0 && idx.size() < MAX_BLK) begin
                idx.push_back(p);
                p += 2;
            end else begin
                pay.push_back(a);
                p += 1;
            end
        end
        foreach (fd[i]) fd[i] = 0;
        foreach (idx[k]) begin
            fd[5*k] = 3;
            for (int i = 0; i < 4; i++) fd[5*k+1+i] = (idx[k] >> (2*i)) & 3;
        end
        pos = 5*idx.size() + 1;
        foreach (pay[j]) fd[pos + pay.size() - 1 - j] = pay[j];
        e.w = '0;
        for (int i = 0; i < FD; i++) e.w[2*i +: 2] = 2'(fd[i]);
        e.len = L + 3*idx.size() + 1;
        e.cnt = idx.size();
        e.lat = L - idx.size() + 2;
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [FW-1:0] w, input int len, input int cnt, input int lat);
        exp_t e;
        e.w = w; e.len = len; e.cnt = cnt; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [2*M-1:0] w, input int len, input exp_t e, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(negedge clk);
        in_valid = 1;
        word_in  = w;
        in_len   = LW'(len);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            nchk++; nerr++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        acc   = cyc;
        sb.push_back(e);
        in_valid = 0;
        word_in  = 2*M'($urandom());
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_in_ready"},  FW'(in_ready),  FW'(1));
        chk({name, "_out_valid"}, FW'(out_valid), FW'(0));
        chk({name, "_word_out"},  word_out,       '0);
        chk({name, "_out_len"},   FW'(out_len),   FW'(0));
        chk({name, "_blk_cnt"},   FW'(blk_cnt),   FW'(0));
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_q = 0;
        end else begin
            if (out_valid && !ov_q) begin
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL spurious_frame: out_valid=1 with nothing outstanding");
                end else begin
                    chk("latency", FW'(cyc - sb[0].acc), FW'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("word_out", word_out,        e.w);
                chk("out_len",  FW'(out_len),    FW'(e.len));
                chk("blk_cnt",  FW'(blk_cnt),    FW'(e.cnt));
            end
            ov_q = out_valid;
        end
    end

    localparam logic [2*M-1:0] W1 = 40'b01_10_11_01;
    localparam logic [2*M-1:0] W2 = 40'b01_00_00_10_11_01;

    initial begin
        exp_t e1, e2, e3, e4, er;
        int   a0, a1, t;
        logic [FW-1:0] snap;
        logic [2*M-1:0] w;
        int   len;

        e1 = mk(FW'(10'b01_10_11_01_00), 5, 0, 6);
        e2 = mk(FW'(20'b01_10_11_01_00_00_00_00_01_11), 10, 1, 7);
        e3 = mk(FW'(24'h002C03), 12, 2, 5);
        e4 = model('0, 20);
        e4.len = 33; e4.cnt = 4; e4.lat = 18;

        #1;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Directed frames
        rdy_mode = 2;
        send(W1, 4, e1, a0);
        send(W2, 6, e2, a0);
        send('0, 5, e3, a0);
        send('0, 20, e4, a0);
        send('0, 0, mk('0, 1, 0, 2), a0);
        drain();

        // Back-to-back throughput: one frame per S+4 cycles
        send(W1, 4, e1, a0);
        send(W1, 4, e1, a1);
        chk("throughput", FW'(a1 - a0), FW'(8));
        drain();

        // Back-pressure
        rdy_mode = 1;
        send(W2, 6, e2, a0);
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_valid", FW'(out_valid), FW'(1));
        snap = word_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            word_in  = 2*M'($urandom());
            in_len   = LW'($urandom_range(0, M));
            chk("bp_in_ready", FW'(in_ready),  FW'(0));
            chk("bp_hold",     word_out,       snap);
            chk("bp_out_valid", FW'(out_valid), FW'(1));
        end
        @(negedge clk);
        in_valid = 0;
        rdy_mode = 2;
        t = 0;
        while (!out_ready && t < 10) begin @(negedge clk); t++; end
        @(posedge clk);
        #1;
        chk("bp_release_in_ready",  FW'(in_ready),  FW'(1));
        chk("bp_release_out_valid", FW'(out_valid), FW'(0));
        drain();

        // Reset mid-scan, then resend
        send(W2, 6, e2, a0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk_reset_vals("midreset");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        send(W2, 6, e2, a0);
        drain();

        // Randomized words, zero-heavy, lengths past saturation included
        rdy_mode = 0;
        for (int n = 0; n < 40; n++) begin
            w = '0;
            for (int d = 0; d < M; d++) begin
                if ($urandom_range(0, 1) == 1) w[2*d +: 2] = 2'($urandom_range(1, 3));
            end
            len = $urandom_range(0, M + 3);
            er = model(w, len);
            send(w, len, er, a0);
        end
        drain();
        rdy_mode = 2;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/rll_constrain.md
# rll_constrain

Run-length-limit encoder that removes runs of zero digits from a DNA payload word and records their positions as marker blocks. It is the transmit-side counterpart of the RLL restore stage: its output frame is consumed directly by that stage, which re-inserts the zero pairs. The encoder sits between payload assembly and synthesis-constraint checking. It runs iteratively, one digit position per cycle, with valid/ready handshakes on both sides.

## Interface
- `M`, default 20: maximum input payload length in digits (2 bits per digit). Must be ≤ 256 because the index field is 8 bits.
- `MAX_BLK`, default 4: maximum number of marker blocks emitted per word.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block idle and can accept a word.
- `word_in`  in  2*M  payload, right-aligned. Digit d occupies bits [2d+1:2d]. The first (top) digit is d = in_len-1.
- `in_len`  in  LW  payload length in digits, where LW = $clog2(M+3*MAX_BLK+2).
- `out_valid`  out  1  encoded frame present.
- `out_ready`  in  1  downstream accepts the frame.
- `word_out`  out  2*(M+1+3*MAX_BLK)  encoded frame, right-aligned.
- `out_len`  out  LW  encoded length in digits.
- `blk_cnt`  out  $clog2(MAX_BLK+1)  number of blocks emitted (R).

## Operation
- **Positions.** Position p counts from the payload top, so p=0 is digit in_len-1.
- **Saturation.** An in_len value greater than M is treated as M.
- **Scan, one step per cycle.**
  - If digits p and p+1 are both 00, p+1 < in_len, and R < MAX_BLK: remove both digits, append a block with index = p, then set p += 2 and R += 1.
  - Otherwise copy digit p to the compressed payload and set p += 1.
  - Removal is greedy and non-overlapping. A run of 3 zeros yields 1 block plus 1 copied 00. A run of 4 zeros yields 2 blocks.
  - A trailing single 00 digit is copied.
  - Once R = MAX_BLK, all remaining digits are copied.
- **Frame layout, from LSB upward.**
  - Block k occupies digits 5k..5k+4.
  - Digit 5k is the flag, 2'b11.
  - Digits 5k+1..5k+4 hold the index in base 4, with digit 5k+4 most significant.
  - Blocks appear in ascending index order.
  - Digit 5R is the terminator, 2'b00.
  - The compressed payload occupies digits 5R+1 upward, keeping original order, with its top digit highest.
- **Lengths.** out_len = in_len + 3R + 1. Bits of word_out above digit out_len-1 are zero.
- **Index coordinates.** Each index is expressed in original (uncompressed) coordinates measured from the frame top. The downstream stage restores blocks in order from digit 0.
- **FSM states.**
  - IDLE: in_ready = 1. On in_valid, capture the word and length, clear p and R, and go to SCAN.
  - SCAN: if p ≥ in_len, go to PACK and do nothing else; otherwise perform one step.
  - PACK: assemble word_out, out_len and blk_cnt, then go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- **Handshakes.**
  - in_ready is asserted only in IDLE.
  - word_out, out_len and blk_cnt are stable while out_valid && !out_ready.
  - in_valid is ignored outside IDLE.
  - A word cannot be accepted in the same cycle that the previous frame is accepted.

## Timing
- **Reset values.** in_ready = 1, out_valid = 0, word_out = 0, out_len = 0, blk_cnt = 0. The FSM is in IDLE.
- **Latency.** With S = in_len - R, out_valid rises S+2 edges after the accept edge: S+1 SCAN edges plus 1 PACK edge. For in_len = 0 this is 2 edges, giving out_len = 1 and word_out = 0.
- **Back-to-back throughput.** One frame per S+4 cycles.
- **Reset mid-operation.** The transaction is dropped. Outputs return to their reset values immediately (asynchronously), and no partial frame is ever presented.

## Structure
- **Package `rll_pkg`** contains:
  - constants RLL_FLAG = 2'b11, RLL_TERM = 2'b00, RLL_IDX_DIGITS = 4, RLL_BLK_DIGITS = 5;
  - the typedef `rll_digit_t` (logic [1:0]);
  - a function converting an 8-bit index to and from its base-4 digit order.
- **Sub-module `rll_hdr_pack`.** Combinational PACK logic that takes the compressed payload, its length, the block list and R, and produces word_out and out_len.
- **Everything else** (FSM, scan datapath, block list) stays in `rll_constrain`.

## Test plan
All scenarios use M = 20 and MAX_BLK = 4.
1. **No zero runs.** in_len = 4, word_in = 8'b01_10_11_01 → R = 0, out_len = 5, word_out = 10'b01_10_11_01_00; out_valid 6 edges after accept.
2. **Single pair.** in_len = 6, top→bottom digits 1,0,0,2,3,1 → one block with index 1, out_len = 10, word_out = 20'b01_10_11_01_00_00_00_00_01_11; out_valid 7 edges after accept.
3. **Run of five zeros.** in_len = 5, all digits 00 → blocks with index 0 and index 2, R = 2, out_len = 12, word_out = 24'h002C03.
4. **Saturation.** in_len = 20, all digits 00 → indices 0, 2, 4, 6; blk_cnt = 4; out_len = 33; digits 21..32 all 00.
5. **Back-pressure.** In scenario 2, hold out_ready = 0 for 5 cycles while toggling in_valid → frame held stable, in_ready = 0, nothing accepted. in_ready rises the cycle after out_ready is accepted.
6. **Reset mid-scan.** Assert rst_n = 0 during SCAN of scenario 2 → all outputs at reset values immediately. Re-sending scenario 2 then yields the scenario 2 frame.
